// File: rtl/noc_pkg.sv
// Shared types for the response egress path: byte classification and the
// input-side packet assembly states.
package noc_pkg;

  typedef enum logic [1:0] {BC_CMD, BC_DATA, BC_NOP} byte_class_e;

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} in_state_e;

  localparam logic [8:0] NOP_BYTE = 9'h100;

  function automatic byte_class_e classify(input logic ctl, input logic [7:0] data);
    if (!ctl) return BC_DATA;
    if ({ctl, data} == NOP_BYTE) return BC_NOP;
    return BC_CMD;
  endfunction

endpackage

// File: rtl/noc_egress_ram.sv
// Byte store for the egress buffer: {ctl,data} per entry plus an end-of-packet
// flag that can be set after the fact when the packet is committed.
module noc_egress_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [8:0]    wr_data_i,
  input  logic          eop_en_i,
  input  logic [AW-1:0] eop_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [8:0]    rd_data_o,
  output logic          rd_eop_o
);

  logic [8:0] mem_q [DEPTH];
  logic       eop_q [DEPTH];

  // NOTE: the arrays carry no reset; the pointers alone decide which entries
  // are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
      eop_q[wr_addr_i] <= 1'b0;
    end
    // Commit marks the previous entry, never the one being written this cycle.
    if (eop_en_i) begin
      eop_q[eop_addr_i] <= 1'b1;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];
  assign rd_eop_o  = eop_q[rd_addr_i];

endmodule

// File: rtl/noc_resp_egress.sv
// Store-and-forward egress buffer: assembles whole response packets from the
// switch byte stream and exposes only committed packets over valid/ready.
module noc_resp_egress
  import noc_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_ctl,
  input  logic [7:0]      in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_ctl,
  output logic [7:0]      out_data,
  output logic            out_sop,
  output logic            out_eop,
  output logic [CNTW-1:0] pkt_count,
  output logic [CNTW-1:0] drop_count,
  output logic [AW:0]     level
);

  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [AW-1:0] IDX_ONE  = 1;
  localparam logic [AW:0]   PTR_FULL = (AW+1)'(DEPTH);

  in_state_e       state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     cmt_ptr_q, cmt_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] pkt_count_q, pkt_count_d;
  logic [CNTW-1:0] drop_count_q, drop_count_d;

  byte_class_e     bc;
  logic [AW:0]     used;
  logic            has_space;
  logic            wr_en, eop_en, drop_inc, rd_fire;
  logic [8:0]      rd_data;
  logic            rd_eop;

  // Space is judged on pre-cycle pointers; a same-cycle read frees nothing.
  assign used      = wr_ptr_q - rd_ptr_q;
  assign has_space = (used != PTR_FULL);
  assign bc        = classify(in_ctl, in_data);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    wr_en     = 1'b0;
    eop_en    = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      IDLE, DROP: begin
        unique case (bc)
          BC_CMD: begin
            if (has_space) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              state_d  = COLLECT;
            end else begin
              drop_inc = 1'b1;
              state_d  = DROP;
            end
          end
          BC_DATA: drop_inc = (state_q == IDLE);
          BC_NOP:  state_d  = IDLE;
          default: ;
        endcase
      end
      COLLECT: begin
        unique case (bc)
          BC_DATA: begin
            if (has_space) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
              wr_ptr_d = cmt_ptr_q;
              drop_inc = 1'b1;
              state_d  = DROP;
            end
          end
          BC_NOP: begin
            eop_en    = 1'b1;
            cmt_ptr_d = wr_ptr_q;
            state_d   = IDLE;
          end
          BC_CMD: begin
            eop_en    = 1'b1;
            cmt_ptr_d = wr_ptr_q;
            if (has_space) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
              drop_inc = 1'b1;
              state_d  = DROP;
            end
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  noc_egress_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk        (clk),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_ptr_q[AW-1:0]),
    .wr_data_i  ({in_ctl, in_data}),
    .eop_en_i   (eop_en),
    .eop_addr_i (wr_ptr_q[AW-1:0] - IDX_ONE),
    .rd_addr_i  (rd_ptr_q[AW-1:0]),
    .rd_data_o  (rd_data),
    .rd_eop_o   (rd_eop)
  );

  assign out_valid = (rd_ptr_q != cmt_ptr_q);
  assign out_ctl   = out_valid ? rd_data[8]   : 1'b0;
  assign out_data  = out_valid ? rd_data[7:0] : 8'h00;
  assign out_sop   = out_ctl & (out_data != 8'h00);
  assign out_eop   = out_valid & rd_eop;
  assign rd_fire   = out_valid & out_ready;

  always_comb begin
    rd_ptr_d     = rd_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    pkt_count_d  = (rd_fire && out_eop) ? pkt_count_q + 1'b1 : pkt_count_q;
    drop_count_d = (drop_inc && (drop_count_q != '1)) ? drop_count_q + 1'b1 : drop_count_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cmt_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cmt_ptr_q    <= cmt_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
  assign level      = cmt_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_noc_resp_egress.sv
// Directed bench for the egress buffer, built with an 8-entry store so the
// full and oversize cases are short.
module tb_noc_resp_egress;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CNTW  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_ctl;
  logic [7:0]      in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_ctl;
  logic [7:0]      out_data;
  logic            out_sop;
  logic            out_eop;
  logic [CNTW-1:0] pkt_count;
  logic [CNTW-1:0] drop_count;
  logic [AW:0]     level;

  int n_pass   = 0;
  int n_checks = 0;

  // Transfer log entries are {eop, sop, ctl, data}.
  logic [10:0] mon_q [$];

  noc_resp_egress #(.DEPTH(DEPTH), .AW(AW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_ctl     (in_ctl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctl    (out_ctl),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .level      (level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) mon_q.push_back({out_eop, out_sop, out_ctl, out_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ctl, input logic [7:0] data);
    in_ctl  = ctl;
    in_data = data;
    tick();
    in_ctl  = 1'b1;
    in_data = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 8'h00);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    in_ctl    = 1'b1;
    in_data   = 8'h00;
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_ctl, out_data, out_sop, out_eop} !== 12'h000)
      $display("FAIL reset_outputs: got %b, want all zero", {out_valid, out_ctl, out_data, out_sop, out_eop});
    else n_pass++;
    n_checks++;
    if (pkt_count !== 16'd0 || drop_count !== 16'd0 || level !== 4'd0)
      $display("FAIL reset_counters: pkt=%0d drop=%0d level=%0d, want 0/0/0", pkt_count, drop_count, level);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [10:0] exp [3];
    exp = '{11'b0_1_1_00000011, 11'b0_0_0_00010001, 11'b1_0_0_00100010};
    mon_q.delete();
    out_ready = 1'b1;
    send(1'b1, 8'h03);
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    send(1'b1, 8'h00);
    idle(5);
    n_checks++;
    if (mon_q.size() != 3) $display("FAIL basic_count: got %0d transfers, want 3", mon_q.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== exp[i])
        $display("FAIL basic_byte%0d: got %h, want %h", i, (i < mon_q.size()) ? mon_q[i] : 11'h7ff, exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (pkt_count !== 16'd1 || level !== 4'd0)
      $display("FAIL basic_tail: pkt=%0d level=%0d, want 1/0", pkt_count, level);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp [4];
    exp = '{11'b0_1_1_00000010, 11'b1_0_0_10101010, 11'b0_1_1_00000101, 11'b1_0_0_00110011};
    mon_q.delete();
    out_ready = 1'b1;
    send(1'b1, 8'h02);
    send(1'b0, 8'hAA);
    send(1'b1, 8'h05);
    send(1'b0, 8'h33);
    send(1'b1, 8'h00);
    idle(6);
    n_checks++;
    if (mon_q.size() != 4) $display("FAIL b2b_count: got %0d transfers, want 4", mon_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== exp[i])
        $display("FAIL b2b_byte%0d: got %h, want %h", i, (i < mon_q.size()) ? mon_q[i] : 11'h7ff, exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (pkt_count !== 16'd3) $display("FAIL b2b_pkt: got %0d, want 3", pkt_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [10:0] exp [5];
    exp = '{11'b0_1_1_00000111, 11'b0_0_0_00000001, 11'b0_0_0_00000010,
            11'b0_0_0_00000011, 11'b1_0_0_00000100};
    out_ready = 1'b0;
    send(1'b1, 8'h07);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    send(1'b0, 8'h04);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_not_yet_valid: got %b, want 0", out_valid);
    else n_pass++;
    send(1'b1, 8'h00);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL bp_valid_after_commit: got %b, want 1", out_valid);
    else n_pass++;
    idle(3);
    n_checks++;
    if ({out_valid, out_sop, out_eop, out_ctl, out_data} !== 12'b1_1_0_1_00000111 || level !== 4'd5)
      $display("FAIL bp_head_held: got v/sop/eop/ctl/data=%b level=%0d, want 110100000111 level=5",
               {out_valid, out_sop, out_eop, out_ctl, out_data}, level);
    else n_pass++;
    mon_q.delete();
    out_ready = 1'b1;
    idle(5);
    n_checks++;
    if (mon_q.size() != 5 || out_valid !== 1'b0 || level !== 4'd0 || pkt_count !== 16'd4)
      $display("FAIL bp_drain: transfers=%0d valid=%b level=%0d pkt=%0d, want 5/0/0/4",
               mon_q.size(), out_valid, level, pkt_count);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== exp[i])
        $display("FAIL bp_byte%0d: got %h, want %h", i, (i < mon_q.size()) ? mon_q[i] : 11'h7ff, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_oversize();
    out_ready = 1'b0;
    send(1'b1, 8'h09);
    for (int i = 0; i < 8; i++) send(1'b0, 8'h40 + 8'(i));
    send(1'b1, 8'h00);
    tick();
    n_checks++;
    if (drop_count !== 16'd1 || level !== 4'd0 || out_valid !== 1'b0)
      $display("FAIL oversize_drop: drop=%0d level=%0d valid=%b, want 1/0/0", drop_count, level, out_valid);
    else n_pass++;
    send(1'b1, 8'h0A);
    send(1'b0, 8'h61);
    send(1'b0, 8'h62);
    send(1'b1, 8'h00);
    n_checks++;
    if (level !== 4'd3 || out_valid !== 1'b1 || out_data !== 8'h0A || out_sop !== 1'b1)
      $display("FAIL oversize_next: level=%0d valid=%b data=%h sop=%b, want 3/1/0a/1",
               level, out_valid, out_data, out_sop);
    else n_pass++;
    out_ready = 1'b1;
    idle(4);
    n_checks++;
    if (pkt_count !== 16'd5 || level !== 4'd0)
      $display("FAIL oversize_drain: pkt=%0d level=%0d, want 5/0", pkt_count, level);
    else n_pass++;
    // Exactly DEPTH bytes fit; a further CMD finds no space.
    out_ready = 1'b0;
    send(1'b1, 8'h0B);
    for (int i = 0; i < 7; i++) send(1'b0, 8'h70 + 8'(i));
    send(1'b1, 8'h00);
    n_checks++;
    if (level !== 4'd8 || drop_count !== 16'd1)
      $display("FAIL full_fit: level=%0d drop=%0d, want 8/1", level, drop_count);
    else n_pass++;
    send(1'b1, 8'h0C);
    send(1'b0, 8'h99);
    send(1'b1, 8'h00);
    n_checks++;
    if (level !== 4'd8 || drop_count !== 16'd2 || out_data !== 8'h0B)
      $display("FAIL full_cmd_drop: level=%0d drop=%0d head=%h, want 8/2/0b", level, drop_count, out_data);
    else n_pass++;
    mon_q.delete();
    out_ready = 1'b1;
    idle(10);
    n_checks++;
    if (mon_q.size() != 8 || pkt_count !== 16'd6 || out_valid !== 1'b0)
      $display("FAIL full_drain: transfers=%0d pkt=%0d valid=%b, want 8/6/0", mon_q.size(), pkt_count, out_valid);
    else n_pass++;
  endtask

  task automatic test_orphan();
    out_ready = 1'b1;
    send(1'b0, 8'h55);
    idle(2);
    n_checks++;
    if (drop_count !== 16'd3 || out_valid !== 1'b0 || level !== 4'd0)
      $display("FAIL orphan: drop=%0d valid=%b level=%0d, want 3/0/0", drop_count, out_valid, level);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(1'b1, 8'h01);
    send(1'b0, 8'h10);
    send(1'b1, 8'h00);
    send(1'b1, 8'h02);
    send(1'b0, 8'h20);
    send(1'b1, 8'h00);
    send(1'b1, 8'h03);
    send(1'b0, 8'h30);
    n_checks++;
    if (level !== 4'd4) $display("FAIL mid_level: got %0d, want 4", level);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || level !== 4'd0 || pkt_count !== 16'd0 || drop_count !== 16'd0)
      $display("FAIL mid_reset: valid=%b level=%0d pkt=%0d drop=%0d, want all 0",
               out_valid, level, pkt_count, drop_count);
    else n_pass++;
    reset = 1'b0;
    mon_q.delete();
    out_ready = 1'b1;
    send(1'b0, 8'h31);
    send(1'b1, 8'h04);
    send(1'b1, 8'h00);
    idle(3);
    n_checks++;
    if (mon_q.size() != 1 || mon_q[0] !== 11'b1_1_1_00000100 || drop_count !== 16'd1 || pkt_count !== 16'd1)
      $display("FAIL post_reset: transfers=%0d first=%h drop=%0d pkt=%0d, want 1/704/1/1",
               mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 11'h000, drop_count, pkt_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_oversize();
    test_orphan();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_resp_egress.md
Name: noc_resp_egress

Overview:
- Store-and-forward egress buffer directly downstream of the 4-device response switch.
- Consumes the switch's `from` byte stream {ctl,data} and strips NOP bubbles.
- Holds only complete response packets and presents them to the host side over a valid/ready handshake.
- Partial or oversize packets are never visible at the output.

Parameters:
DEPTH, 64, buffer entries (power of two, >=8)
AW, $clog2(DEPTH), entry index width
CNTW, 16, packet/drop counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_ctl  in  1  switch noc_from_dev_ctl
in_data  in  8  switch noc_from_dev_data
out_valid  out  1  head entry belongs to a committed packet
out_ready  in  1  consumer accepts out byte this cycle
out_ctl  out  1  ctl bit of head byte
out_data  out  8  data of head byte
out_sop  out  1  head byte is a command byte
out_eop  out  1  head byte is last byte of its packet
pkt_count  out  CNTW  packets delivered (eop transfers), wraps
drop_count  out  CNTW  packets discarded, saturates at all-ones
level  out  AW+1  committed bytes not yet read

Behaviour:
- Byte classes:
  - CMD: ctl=1, data!=0.
  - DATA: ctl=0.
  - NOP: ctl=1, data=0.
- Reset (sync, active-high):
  - All pointers=0; input FSM=IDLE.
  - out_valid=0, out_sop=0, out_eop=0, out_ctl=0, out_data=0.
  - pkt_count=0, drop_count=0, level=0.
- Storage:
  - mem[DEPTH] x 9 bits {ctl,data}, plus eop_flag[DEPTH] x 1.
  - Pointers wr_ptr, cmt_ptr, rd_ptr are AW+1 bits, wrapping modulo 2*DEPTH.
  - free = DEPTH - (wr_ptr - rd_ptr).
- Input FSM (one byte per cycle, no backpressure upstream):
  - IDLE:
    - CMD with free>0 → write, wr_ptr++, go COLLECT.
    - CMD with free=0 → drop_count++, go DROP.
    - DATA → orphan, ignore, drop_count++.
    - NOP → stay.
  - COLLECT:
    - DATA with free>0 → write, wr_ptr++.
    - NOP → commit, go IDLE.
    - CMD → commit current packet, then write the CMD as first byte of a new packet (if free>0 after commit, else drop_count++ and go DROP). Stay COLLECT.
    - DATA with free=0 → wr_ptr:=cmt_ptr (rewind), drop_count++, go DROP.
  - DROP:
    - Discard DATA.
    - NOP → IDLE.
    - CMD → handled as in IDLE.
  - Commit = eop_flag[wr_ptr-1]:=1, cmt_ptr:=wr_ptr. All other written entries get eop_flag=0.
- Output (first-word fall-through, combinational from registered state):
  - out_valid = (rd_ptr != cmt_ptr).
  - {out_ctl,out_data} = mem[rd_ptr]; out_sop = out_ctl & (out_data!=0); out_eop = eop_flag[rd_ptr].
  - When out_valid=0, the out_* data fields are 0.
  - Transfer when out_valid & out_ready → rd_ptr++.
  - If out_eop is set on a transfer, pkt_count++ (wraps).
  - out_ready while !out_valid has no effect.
  - A byte stays stable while valid & !ready.
- Latency: the last byte of a packet is written at cycle N. Commit occurs at cycle N+1 (when the terminating NOP/CMD arrives), and out_valid rises at N+2.
- level = cmt_ptr - rd_ptr.
- Simultaneous read and write in one cycle are both honoured. free is evaluated from pre-cycle pointers, so a same-cycle read does not create space.
- A packet longer than DEPTH is always dropped.
- Reset mid-packet discards all contents, including committed but unread bytes.

Decomposition:
- Shared package noc_pkg holds:
  - The byte-class enum {BC_CMD, BC_DATA, BC_NOP} and a classify function.
  - NOP_BYTE = 9'h100.
  - The input FSM enum {IDLE, COLLECT, DROP}.
- One natural sub-module: noc_egress_ram, a DEPTH x 10 single-write/single-read array with a separate eop write port for the retro commit.

Test Plan:
- Send CMD 0x03, DATA 0x11, 0x22, NOP, with out_ready=1 → out bytes 0x103, 0x011, 0x022. sop on the first byte, eop on 0x022. pkt_count=1, no NOP emitted.
- Send CMD 0x02, DATA 0xAA, then CMD 0x05 with no NOP between → two packets delivered. eop on 0xAA; second sop is 0x105.
- out_ready=0 while packet A (5 bytes) commits → out_valid=1, head held at A's CMD, level=5. Release → 5 transfers over 5 cycles.
- DEPTH=8, out_ready=0: send CMD plus 8 DATA → packet dropped, drop_count=1, level=0. A following 3-byte packet commits normally.
- DATA 0x55 with no preceding CMD → ignored, drop_count=1, out_valid stays 0.
- Reset asserted mid-COLLECT after 2 committed packets → next cycle out_valid=0, level=0, pkt_count=0, drop_count=0.
